// File: rtl/tx_interp_pkg.sv
// -----------------------------------------------------------------------------
// tx_interp_pkg
// Shared constants, types and helpers for the transmit polyphase interpolator.
//   L      interpolation factor (phases per input sample)
//   TAPS   prototype low-pass length; P = TAPS/L taps per phase
//   DW     I/Q sample width (signed); CW coefficient width (signed Q2.14)
//   ACC_W  accumulator width; FRAC fractional bits removed on output
//   COEFS  prototype x L, symmetric, so every phase sums to 16384 (unity DC)
//   state_t controller states
// -----------------------------------------------------------------------------
package tx_interp_pkg;

    localparam int L     = 4;
    localparam int TAPS  = 64;
    localparam int P     = TAPS / L;
    localparam int DW    = 12;
    localparam int CW    = 16;
    localparam int ACC_W = 32;
    localparam int FRAC  = 14;

    localparam int KW = $clog2(P);
    localparam int PW = $clog2(L);
    localparam int AW = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    // Phase p of the polyphase bank uses COEFS[k*L + p], k = 0..P-1.
    localparam logic signed [CW-1:0] COEFS [0:TAPS-1] = '{
        -16'sd50,   -16'sd120,  -16'sd30,    16'sd170,
         16'sd200,  -16'sd60,   -16'sd330,  -16'sd210,
         16'sd230,   16'sd450,   16'sd100,  -16'sd480,
        -16'sd540,   16'sd140,   16'sd780,   16'sd490,
        -16'sd550,  -16'sd1080, -16'sd240,   16'sd1120,
         16'sd1250, -16'sd330,  -16'sd1880, -16'sd1220,
         16'sd1420,  16'sd2950,  16'sd700,  -16'sd4300,
        -16'sd5402,  16'sd1600,  16'sd13734, 16'sd24256,
         16'sd24256, 16'sd13734, 16'sd1600, -16'sd5402,
        -16'sd4300,  16'sd700,   16'sd2950,  16'sd1420,
        -16'sd1220, -16'sd1880, -16'sd330,   16'sd1250,
         16'sd1120, -16'sd240,  -16'sd1080, -16'sd550,
         16'sd490,   16'sd780,   16'sd140,  -16'sd540,
        -16'sd480,   16'sd100,   16'sd450,   16'sd230,
        -16'sd210,  -16'sd330,  -16'sd60,    16'sd200,
         16'sd170,  -16'sd30,   -16'sd120,  -16'sd50
    };

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX - 1;

    // Round half-up (add half LSB, arithmetic shift) then clamp to DW bits.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        logic signed [DW-1:0]    res;
        r = (acc + RND_HALF) >>> FRAC;
        if (r > SAT_MAX) begin
            res = SAT_MAX[DW-1:0];
        end else if (r < SAT_MIN) begin
            res = SAT_MIN[DW-1:0];
        end else begin
            res = r[DW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/tx_interp_mac.sv
// -----------------------------------------------------------------------------
// tx_interp_mac
// One channel of the interpolator datapath: P-entry delay line, one
// multiply-accumulate per cycle, and a rounded/saturated output register.
//   clk, rst   clock, synchronous active-high reset (clears everything)
//   shift_i    push din_i into x[0], shift x[k] <= x[k-1]
//   clr_i      clear the accumulator (start of a phase)
//   en_i       accumulate x[k_i] * coef_i
//   last_i     this accumulate is the final tap; load dout_o
//   k_i        tap index within the phase
//   din_i      new input sample
//   coef_i     coefficient for the current tap/phase
//   dout_o     rounded, saturated phase result (holds until next phase ends)
// -----------------------------------------------------------------------------
module tx_interp_mac
    import tx_interp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 last_i,
    input  logic [KW-1:0]        k_i,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [CW-1:0] coef_i,
    output logic signed [DW-1:0] dout_o
);

    logic signed [DW-1:0]    x_q [0:P-1];
    logic signed [DW+CW-1:0] prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [DW-1:0]    dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < P; i++) begin
                x_q[i] <= '0;
            end
        end else if (shift_i) begin
            x_q[0] <= din_i;
            for (int i = 1; i < P; i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

    assign prod  = x_q[k_i] * coef_i;
    assign acc_d = acc_q + {{(ACC_W-DW-CW){prod[DW+CW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    // Output is captured from the final sum directly, so it is valid in the
    // same cycle the controller raises out_valid and stays put under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (en_i && last_i) begin
            dout_q <= round_sat(acc_d);
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/tx_interp_fir.sv
// -----------------------------------------------------------------------------
// tx_interp_fir
// Polyphase interpolate-by-L FIR for I/Q. Each accepted sample yields L
// outputs (phase 0 first), each computed with P sequential MACs per channel.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake; ready only in IDLE
//   in_data_i/in_data_q      signed DW-bit input sample
//   out_valid/out_ready      output handshake; data held while stalled
//   out_data_i/out_data_q    signed DW-bit filtered output
// -----------------------------------------------------------------------------
module tx_interp_fir
    import tx_interp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data_i,
    input  logic signed [DW-1:0] in_data_q,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data_i,
    output logic signed [DW-1:0] out_data_q,
    input  logic                 out_ready
);

    state_t               state_q;
    logic [PW-1:0]        p_q;
    logic [KW-1:0]        k_q;
    logic                 out_valid_q;

    logic                 accept;
    logic                 last_tap;
    logic                 mac_en;
    logic                 acc_clr;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef;

    logic signed [DW-1:0] ch_din  [0:1];
    logic signed [DW-1:0] ch_dout [0:1];

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_tap = (k_q == KW'(P - 1));
    assign mac_en   = (state_q == MAC);
    // Accumulator restarts on a new sample or when moving to the next phase.
    assign acc_clr  = accept || ((state_q == OUT) && out_ready && (p_q != PW'(L - 1)));

    assign coef_addr = AW'(k_q) * AW'(L) + AW'(p_q);
    assign coef      = COEFS[coef_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= MAC;
                        p_q     <= '0;
                        k_q     <= '0;
                    end
                end
                MAC: begin
                    if (last_tap) begin
                        k_q         <= '0;
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (p_q != PW'(L - 1)) begin
                            p_q     <= p_q + PW'(1);
                            state_q <= MAC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ch_din[0] = in_data_i;
    assign ch_din[1] = in_data_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        tx_interp_mac u_mac (
            .clk     (clk),
            .rst     (rst),
            .shift_i (accept),
            .clr_i   (acc_clr),
            .en_i    (mac_en),
            .last_i  (last_tap),
            .k_i     (k_q),
            .din_i   (ch_din[gi]),
            .coef_i  (coef),
            .dout_o  (ch_dout[gi])
        );
    end

    // Held low while rst is asserted so nothing is offered during reset.
    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = out_valid_q;
    assign out_data_i = ch_dout[0];
    assign out_data_q = ch_dout[1];

endmodule

// File: tb/tb_tx_interp_fir.sv
// -----------------------------------------------------------------------------
// tb_tx_interp_fir
// Directed bench for tx_interp_fir: reset, impulse response, latency/rate,
// DC saturation, backpressure, reset mid-MAC and ignored input while busy.
// -----------------------------------------------------------------------------
module tb_tx_interp_fir;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic signed [11:0]  in_data_i;
    logic signed [11:0]  in_data_q;
    logic                in_ready;
    logic                out_valid;
    logic signed [11:0]  out_data_i;
    logic signed [11:0]  out_data_q;
    logic                out_ready;

    int errors = 0;
    int checks = 0;
    int stall_bad;
    int got_i [$];
    int got_q [$];

    // Prototype x 4, Q2.14, symmetric.
    int H_REF [64] = '{
        -50, -120, -30, 170, 200, -60, -330, -210,
        230, 450, 100, -480, -540, 140, 780, 490,
        -550, -1080, -240, 1120, 1250, -330, -1880, -1220,
        1420, 2950, 700, -4300, -5402, 1600, 13734, 24256,
        24256, 13734, 1600, -5402, -4300, 700, 2950, 1420,
        -1220, -1880, -330, 1250, 1120, -240, -1080, -550,
        490, 780, 140, -540, -480, 100, 450, 230,
        -210, -330, -60, 200, 170, -30, -120, -50
    };

    tx_interp_fir dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data_i  (in_data_i),
        .in_data_q  (in_data_q),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data_i (out_data_i),
        .out_data_q (out_data_q),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Send one sample and collect its 4 outputs into got_i/got_q.
    // stall_at selects a phase to hold out_ready low for stall_len cycles.
    task automatic send_sample(input int si, input int sq, input int stall_at,
                               input int stall_len, input bit noise);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin
            step();
            w++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout_in_ready got %b required 1", in_ready);
            return;
        end
        in_valid  = 1'b1;
        in_data_i = 12'(si);
        in_data_q = 12'(sq);
        step();
        in_valid  = 1'b0;
        in_data_i = '0;
        in_data_q = '0;
        for (int p = 0; p < 4; p++) begin
            w = 0;
            while (out_valid !== 1'b1 && w < 100) begin
                if (noise) begin
                    in_valid  = 1'($urandom_range(0, 1));
                    in_data_i = 12'($urandom);
                    in_data_q = 12'($urandom);
                end
                step();
                w++;
            end
            in_valid = 1'b0;
            if (out_valid !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL timeout_out_valid phase %0d got %b required 1", p, out_valid);
                return;
            end
            got_i.push_back(int'(out_data_i));
            got_q.push_back(int'(out_data_q));
            if (p == stall_at) begin
                out_ready = 1'b0;
                for (int c = 0; c < stall_len; c++) begin
                    step();
                    if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                        int'(out_data_i) != got_i[$] || int'(out_data_q) != got_q[$])
                        stall_bad++;
                end
                out_ready = 1'b1;
            end
            step();
        end
    endtask

    task automatic send_impulse(input int stall_sample, input int stall_len, input bit noise);
        for (int n = 0; n < 16; n++) begin
            send_sample((n == 0) ? 1024 : 0, 0, (n == stall_sample) ? 2 : -1, stall_len, noise);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data_i = '0;
        in_data_q = '0;
        out_ready = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++; if (out_data_i !== 12'sd0) begin errors++; $display("FAIL reset_out_i got %0d required 0", out_data_i); end
        checks++; if (out_data_q !== 12'sd0) begin errors++; $display("FAIL reset_out_q got %0d required 0", out_data_q); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b required 0", out_valid); end
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_impulse();
        int e;
        got_i.delete();
        got_q.delete();
        send_impulse(-1, 0, 1'b0);
        checks++; if (got_i.size() != 64) begin errors++; $display("FAIL impulse_count got %0d required 64", got_i.size()); end
        for (int j = 0; j < 64 && j < got_i.size(); j++) begin
            e = (1024 * H_REF[j] + 8192) >>> 14;
            checks++; if (got_i[j] != e) begin errors++; $display("FAIL impulse_i[%0d] got %0d required %0d", j, got_i[j], e); end
            checks++; if (got_q[j] != 0) begin errors++; $display("FAIL impulse_q[%0d] got %0d required 0", j, got_q[j]); end
            $display("impulse out %0d: i=%0d q=%0d", j, got_i[j], got_q[j]);
        end
        if (got_i.size() > 32) begin
            checks++; if (got_i[32] != 1516) begin errors++; $display("FAIL impulse_peak got %0d required 1516", got_i[32]); end
        end
    endtask

    // s counts edges after the accept edge; a level observed just after edge
    // t+s is what edge t+s+1 samples, so "valid at cycle t+17" is s=16.
    task automatic test_latency();
        int seen [$];
        logic rdy67;
        logic rdy68;
        int w;
        rdy67 = 1'bx;
        rdy68 = 1'bx;
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin step(); w++; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL latency_start_ready got %b required 1", in_ready); end
        in_valid  = 1'b1;
        in_data_i = 12'sd100;
        in_data_q = -12'sd100;
        step();
        in_valid  = 1'b0;
        for (int s = 1; s <= 68; s++) begin
            step();
            if (out_valid === 1'b1) seen.push_back(s);
            if (s == 67) rdy67 = in_ready;
            if (s == 68) rdy68 = in_ready;
        end
        checks++; if (seen.size() != 4) begin errors++; $display("FAIL latency_valid_count got %0d required 4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] != 16 + 17 * i) begin
                errors++;
                $display("FAIL latency_out%0d got t+%0d required t+%0d", i, seen[i] + 1, 17 + 17 * i);
            end
        end
        checks++; if (rdy67 !== 1'b0) begin errors++; $display("FAIL latency_ready_t68 got %b required 0", rdy67); end
        checks++; if (rdy68 !== 1'b1) begin errors++; $display("FAIL latency_ready_t69 got %b required 1", rdy68); end
        $display("latency: %0d valid outputs, in_ready at t+69 = %b", seen.size(), rdy68);
    endtask

    task automatic test_dc_sat();
        pulse_reset();
        got_i.delete();
        got_q.delete();
        for (int n = 0; n < 40; n++) begin
            send_sample(2047, -2048, -1, 0, 1'b0);
        end
        checks++; if (got_i.size() != 160) begin errors++; $display("FAIL dc_count got %0d required 160", got_i.size()); end
        // Sample 8, phase 0: partial gain 20814/16384 overshoots full scale.
        if (got_i.size() > 32) begin
            checks++; if (got_i[32] != 2047) begin errors++; $display("FAIL dc_clamp_i got %0d required 2047", got_i[32]); end
            checks++; if (got_q[32] != -2048) begin errors++; $display("FAIL dc_clamp_q got %0d required -2048", got_q[32]); end
        end
        for (int j = 32; j < 60 && j < got_i.size(); j++) begin
            checks++; if (got_i[j] <= 0) begin errors++; $display("FAIL dc_sign_i[%0d] got %0d required >0", j, got_i[j]); end
            checks++; if (got_q[j] >= 0) begin errors++; $display("FAIL dc_sign_q[%0d] got %0d required <0", j, got_q[j]); end
        end
        for (int j = 60; j < 160 && j < got_i.size(); j++) begin
            checks++; if (got_i[j] != 2047) begin errors++; $display("FAIL dc_ss_i[%0d] got %0d required 2047", j, got_i[j]); end
            checks++; if (got_q[j] != -2048) begin errors++; $display("FAIL dc_ss_q[%0d] got %0d required -2048", j, got_q[j]); end
        end
        $display("dc: %0d outputs, last i=%0d q=%0d", got_i.size(),
                 (got_i.size() > 0) ? got_i[$] : 0, (got_q.size() > 0) ? got_q[$] : 0);
    endtask

    task automatic test_backpressure();
        int e;
        pulse_reset();
        got_i.delete();
        got_q.delete();
        stall_bad = 0;
        send_impulse(7, 10, 1'b0);
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles required 0", stall_bad); end
        checks++; if (got_i.size() != 64) begin errors++; $display("FAIL stall_count got %0d required 64", got_i.size()); end
        for (int j = 0; j < 64 && j < got_i.size(); j++) begin
            e = (1024 * H_REF[j] + 8192) >>> 14;
            checks++; if (got_i[j] != e) begin errors++; $display("FAIL stall_i[%0d] got %0d required %0d", j, got_i[j], e); end
            checks++; if (got_q[j] != 0) begin errors++; $display("FAIL stall_q[%0d] got %0d required 0", j, got_q[j]); end
        end
        $display("backpressure: 10-cycle stall on output 30, %0d outputs", got_i.size());
    endtask

    task automatic test_reset_mid_mac();
        int e;
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin step(); w++; end
        in_valid  = 1'b1;
        in_data_i = 12'sd1024;
        in_data_q = 12'sd512;
        step();
        in_valid  = 1'b0;
        in_data_i = '0;
        in_data_q = '0;
        for (int s = 1; s < 8; s++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b required 1", in_ready); end
        got_i.delete();
        got_q.delete();
        send_impulse(-1, 0, 1'b0);
        checks++; if (got_i.size() != 64) begin errors++; $display("FAIL midrst_count got %0d required 64", got_i.size()); end
        for (int j = 0; j < 64 && j < got_i.size(); j++) begin
            e = (1024 * H_REF[j] + 8192) >>> 14;
            checks++; if (got_i[j] != e) begin errors++; $display("FAIL midrst_i[%0d] got %0d required %0d", j, got_i[j], e); end
            checks++; if (got_q[j] != 0) begin errors++; $display("FAIL midrst_q[%0d] got %0d required 0", j, got_q[j]); end
        end
        $display("reset mid-MAC: %0d clean outputs collected", got_i.size());
    endtask

    task automatic test_ignored_input();
        int e;
        pulse_reset();
        got_i.delete();
        got_q.delete();
        send_impulse(-1, 0, 1'b1);
        checks++; if (got_i.size() != 64) begin errors++; $display("FAIL ignore_count got %0d required 64", got_i.size()); end
        for (int j = 0; j < 64 && j < got_i.size(); j++) begin
            e = (1024 * H_REF[j] + 8192) >>> 14;
            checks++; if (got_i[j] != e) begin errors++; $display("FAIL ignore_i[%0d] got %0d required %0d", j, got_i[j], e); end
            checks++; if (got_q[j] != 0) begin errors++; $display("FAIL ignore_q[%0d] got %0d required 0", j, got_q[j]); end
        end
        $display("ignored input: %0d outputs with in_valid noise while busy", got_i.size());
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_latency();
        test_dc_sat();
        test_backpressure();
        test_reset_mid_mac();
        test_ignored_input();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
